// File: rtl/rr_arbiter_4.sv
// Four-requester round-robin arbiter with hold-until-release grants and registered one-hot output.
// Optional forced release after MAX_HOLD cycles is built when ARB_TIMEOUT_EN is defined.
module rr_arbiter_4 #(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [3:0] req,
    input  logic       done,
    output logic [3:0] gnt,
    output logic [1:0] gnt_idx,
    output logic       gnt_valid,
    output logic       timeout
);

    localparam int unsigned N_REQ = 4;
    localparam int unsigned IDX_W = 2;

    if (MAX_HOLD == 0 || MAX_HOLD > 255) begin : g_bad_max_hold
        $error("rr_arbiter_4: MAX_HOLD must be within 1..255");
    end

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   last_q, last_d;
    logic [IDX_W-1:0]   gnt_idx_q, gnt_idx_d;
    logic               gnt_valid_q, gnt_valid_d;
    logic [N_REQ-1:0]   gnt_q, gnt_d;
    logic [IDX_W-1:0]   pick_idle_c, pick_rel_c;
    logic               any_req_c, owner_req_c, expire_c, release_c;

    // First requester after l in circular order l+1, l+2, l+3, l.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                                 input logic [IDX_W-1:0] l);
        logic [IDX_W-1:0] w;
        logic [IDX_W-1:0] c;
        logic             found;
        w     = l;
        found = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            c = l + IDX_W'(k);
            if (!found && r[c]) begin
                w     = c;
                found = 1'b1;
            end
        end
        return w;
    endfunction

    assign any_req_c   = |req;
    assign owner_req_c = req[gnt_idx_q];
    assign pick_idle_c = rr_pick(req, last_q);
    assign pick_rel_c  = rr_pick(req, gnt_idx_q);

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    logic [7:0] hold_cnt_q, hold_cnt_d;
    logic       timeout_q, timeout_d;
    logic       forced_c;

    assign expire_c = (hold_cnt_q == HOLD_LAST);
    // Expiry only counts as forced when no ordinary release happens in the same cycle.
    assign forced_c = expire_c & ~done & owner_req_c;
    assign timeout  = timeout_q;
`else
    assign expire_c = 1'b0;
    assign timeout  = 1'b0;
`endif

    assign release_c = done | ~owner_req_c | expire_c;

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        gnt_idx_d   = gnt_idx_q;
        gnt_valid_d = gnt_valid_q;
`ifdef ARB_TIMEOUT_EN
        hold_cnt_d  = hold_cnt_q;
        timeout_d   = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                gnt_valid_d = 1'b0;
                gnt_idx_d   = '0;
                if (en && any_req_c) begin
                    state_d     = BUSY;
                    gnt_idx_d   = pick_idle_c;
                    gnt_valid_d = 1'b1;
`ifdef ARB_TIMEOUT_EN
                    hold_cnt_d  = '0;
`endif
                end
            end
            BUSY: begin
                if (release_c) begin
                    // Releasing owner becomes lowest priority for the same-edge re-arbitration.
                    last_d = gnt_idx_q;
`ifdef ARB_TIMEOUT_EN
                    timeout_d = forced_c;
`endif
                    if (en && any_req_c) begin
                        gnt_idx_d   = pick_rel_c;
                        gnt_valid_d = 1'b1;
`ifdef ARB_TIMEOUT_EN
                        hold_cnt_d  = '0;
`endif
                    end else begin
                        state_d     = IDLE;
                        gnt_idx_d   = '0;
                        gnt_valid_d = 1'b0;
                    end
                end else begin
`ifdef ARB_TIMEOUT_EN
                    hold_cnt_d = hold_cnt_q + 8'd1;
`endif
                end
            end
            default: begin
                state_d     = IDLE;
                gnt_idx_d   = '0;
                gnt_valid_d = 1'b0;
            end
        endcase
        gnt_d = gnt_valid_d ? (N_REQ'(1) << gnt_idx_d) : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            last_q      <= 2'd3;
            gnt_idx_q   <= '0;
            gnt_valid_q <= 1'b0;
            gnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            gnt_idx_q   <= gnt_idx_d;
            gnt_valid_q <= gnt_valid_d;
            gnt_q       <= gnt_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            hold_cnt_q <= hold_cnt_d;
            timeout_q  <= timeout_d;
        end
    end
`endif

    assign gnt       = gnt_q;
    assign gnt_idx   = gnt_idx_q;
    assign gnt_valid = gnt_valid_q;

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Bench for rr_arbiter_4: directed scenarios plus random traffic against a cycle-level ownership model.
module tb_rr_arbiter_4;

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned MH    = 4;
    localparam bit          TO_EN = 1'b1;
`else
    localparam int unsigned MH    = 16;
    localparam bit          TO_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [3:0] req;
    logic       done;
    logic [3:0] gnt;
    logic [1:0] gnt_idx;
    logic       gnt_valid;
    logic       timeout;

    int n_chk  = 0;
    int n_fail = 0;

    // Model: current owner (-1 when idle), last owner, cycles held, and expected timeout pulse.
    int m_owner;
    int m_last;
    int m_hold;
    bit m_to;

    rr_arbiter_4 #(.MAX_HOLD(MH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .req       (req),
        .done      (done),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    function automatic int pick(input logic [3:0] r, input int l);
        for (int k = 1; k <= 4; k++)
            if (r[(l + k) % 4]) return (l + k) % 4;
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_last  = 3;
        m_hold  = 0;
        m_to    = 1'b0;
    endtask

    task automatic model_edge(input logic e, input logic [3:0] r, input logic d);
        bit normal, expire;
        m_to = 1'b0;
        if (m_owner < 0) begin
            if (e && r != 4'b0000) begin
                m_owner = pick(r, m_last);
                m_hold  = 0;
            end
        end else begin
            normal = d || !r[m_owner];
            expire = TO_EN && (m_hold == int'(MH) - 1);
            if (normal || expire) begin
                m_to   = expire && !normal;
                m_last = m_owner;
                if (e && r != 4'b0000) begin
                    m_owner = pick(r, m_last);
                    m_hold  = 0;
                end else begin
                    m_owner = -1;
                end
            end else begin
                m_hold++;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_outputs(input string tag);
        logic [3:0] e_gnt;
        logic [1:0] e_idx;
        e_gnt = (m_owner < 0) ? 4'b0000 : (4'b0001 << m_owner);
        e_idx = (m_owner < 0) ? 2'd0 : 2'(m_owner);
        chk({tag, ".gnt"},       gnt,                 e_gnt);
        chk({tag, ".gnt_idx"},   {2'b00, gnt_idx},    {2'b00, e_idx});
        chk({tag, ".gnt_valid"}, {3'b000, gnt_valid}, {3'b000, m_owner >= 0});
        chk({tag, ".timeout"},   {3'b000, timeout},   {3'b000, m_to});
    endtask

    // Apply inputs, let one rising edge happen, then compare just after it.
    task automatic step(input string tag, input logic e, input logic [3:0] r, input logic d);
        en   = e;
        req  = r;
        done = d;
        @(posedge clk);
        model_edge(e, r, d);
        #1;
        check_outputs(tag);
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        req   = 4'b0000;
        done  = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outputs("reset");
        rst_n = 1'b1;

        // Single requester 0, then asynchronous reset in the middle of the grant.
        step("req0", 1'b1, 4'b0001, 1'b0);
        chk("req0.onehot", gnt, 4'b0001);
        step("req0_hold", 1'b1, 4'b0001, 1'b0);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        check_outputs("async_rst");
        @(posedge clk);
        #1 rst_n = 1'b1;
        check_outputs("async_rst_held");

        // All requesting, done every third cycle: rotation 0,1,2,3,0 with no gap.
        for (int g = 0; g < 5; g++) begin
            step("rot", 1'b1, 4'b1111, 1'b0);
            step("rot", 1'b1, 4'b1111, 1'b0);
            step("rot", 1'b1, 4'b1111, 1'b1);
        end
        step("rot_end", 1'b0, 4'b0000, 1'b1);
        step("rot_idle", 1'b1, 4'b0000, 1'b0);
        chk("rot_idle.onehot", gnt, 4'b0000);

        // Owner 2 drops its request; then requester 0 drops with nobody left.
        step("own2", 1'b1, 4'b0100, 1'b0);
        step("own2", 1'b1, 4'b0101, 1'b0);
        step("own2_drop", 1'b1, 4'b0001, 1'b0);
        chk("own2_drop.onehot", gnt, 4'b0001);
        step("own0_drop", 1'b1, 4'b0000, 1'b0);
        step("idle", 1'b1, 4'b0000, 1'b1);

        // Enable low during a grant: grant held until done, then nothing until enable returns.
        step("own1", 1'b1, 4'b0010, 1'b0);
        step("en_lo", 1'b0, 4'b1010, 1'b0);
        step("en_lo", 1'b0, 4'b1010, 1'b0);
        step("en_lo_done", 1'b0, 4'b1010, 1'b1);
        step("en_lo_idle", 1'b0, 4'b1010, 1'b0);
        step("en_lo_idle", 1'b0, 4'b1010, 1'b0);
        step("en_hi", 1'b1, 4'b1010, 1'b0);
        chk("en_hi.onehot", gnt, 4'b1000);
        step("clear", 1'b1, 4'b0000, 1'b0);

        // Sole requester 3 re-granted back-to-back after done.
        step("sole3", 1'b1, 4'b1000, 1'b0);
        step("sole3_done", 1'b1, 4'b1000, 1'b1);
        step("sole3_regrant", 1'b1, 4'b1000, 1'b0);
        chk("sole3.valid", {3'b000, gnt_valid}, 4'b0001);
        step("sole3_done", 1'b1, 4'b1000, 1'b1);
        step("clear", 1'b1, 4'b0000, 1'b0);

        // Long hold with two requesters and no done (forced release only with the timeout build).
        for (int c = 0; c < 100; c++) step("long_hold", 1'b1, 4'b0011, 1'b0);
        step("clear", 1'b1, 4'b0000, 1'b0);

        // Random traffic.
        for (int c = 0; c < 600; c++) begin
            logic       e, d;
            logic [3:0] r;
            e = ($urandom_range(0, 7) != 0);
            r = 4'($urandom);
            d = ($urandom_range(0, 3) == 0);
            step("rand", e, r, d);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
